// File: rtl/irq_pkg.sv
// irq_pkg: shared types and helper functions for the vectored interrupt controller.
//
// Contents:
//   irq_state_t  - request FSM states (IDLE, REQ)
//   MAX_IRQ      - largest supported number of sources
//   ffs_low      - index of the lowest set bit (0 when no bit is set)
//   higher_mask  - sources allowed to preempt the current in-service set
//
// Both functions work on 32-bit vectors, the widest source count supported.
// Callers zero-extend their NUM_IRQ-wide vectors on the way in.
package irq_pkg;

    localparam int MAX_IRQ = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_t;

    // The scan runs from the top down, so the last hit is the lowest index.
    // The caller checks for an all-zero input separately.
    function automatic int ffs_low(input logic [MAX_IRQ-1:0] v);
        int r;
        r = 0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

    // Isolate the lowest set isr bit (the highest-priority level in service),
    // then subtract one to get every strictly-lower index. With isr == 0 the
    // subtraction wraps to all ones, so every source qualifies.
    function automatic logic [MAX_IRQ-1:0] higher_mask(input logic [MAX_IRQ-1:0] isr);
        logic [MAX_IRQ-1:0] lowest;
        lowest = isr & (~isr + 32'd1);
        return lowest - 32'd1;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: core-side handshake between the interrupt controller and
// the core's control unit / PC logic.
//
// Signals:
//   int_en        core -> ctrl  global interrupt enable (level)
//   int_ack       core -> ctrl  core accepts the current request
//   iret          core -> ctrl  return-from-interrupt, 1-cycle pulse
//   int_req       ctrl -> core  interrupt request
//   int_id        ctrl -> core  id of the requested source
//   vec_addr      ctrl -> core  vector address of the requested source
//   spurious_iret ctrl -> core  pulse when iret arrives with nothing in service
//
// Modports: master = core side, slave = controller side.
interface irq_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int DATA_W  = 32
) ();

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic              int_en;
    logic              int_ack;
    logic              iret;
    logic              int_req;
    logic [ID_W-1:0]   int_id;
    logic [DATA_W-1:0] vec_addr;
    logic              spurious_iret;

    modport master (
        output int_en,
        output int_ack,
        output iret,
        input  int_req,
        input  int_id,
        input  vec_addr,
        input  spurious_iret
    );

    modport slave (
        input  int_en,
        input  int_ack,
        input  iret,
        output int_req,
        output int_id,
        output vec_addr,
        output spurious_iret
    );

endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: find-first-set priority encoder; index 0 has highest priority.
//
// Ports:
//   req    in  N     request vector
//   valid  out 1     at least one request bit set
//   id     out ID_W  index of the lowest set bit (0 when valid is low)
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]                          req,
    output logic                                  valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  id
);

    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    assign valid = |req;
    assign id    = ID_W'(ffs_low(MAX_IRQ'(req)));

endmodule

// File: rtl/irq_controller.sv
// irq_controller: vectored, prioritised, maskable, edge-triggered interrupt
// controller with in-service tracking and preemption.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   asynchronous active-low reset
//   irq_in     in   NUM_IRQ source lines, rising-edge triggered
//   mask_wr    in   load the enable register from mask_data
//   mask_data  in   new enable bits (1 = enabled)
//   pend_clr   in   software clear of pending bits
//   core       if   core handshake (int_en/int_ack/iret in, int_req/int_id/
//                   vec_addr/spurious_iret out)
//   pending_o  out  pending register
//   isr_o      out  in-service register
module irq_controller
    import irq_pkg::*;
#(
    parameter int                NUM_IRQ    = 8,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] VEC_BASE   = 'h100,
    parameter int                VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic [NUM_IRQ-1:0] pend_clr,
    irq_controller_if.slave    core,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic [NUM_IRQ-1:0] isr_o
);

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] isr;

    logic [NUM_IRQ-1:0] edges;
    logic [NUM_IRQ-1:0] higher;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] iret_clr;
    logic               ack_fire;

    irq_state_t         state;
    logic               int_req_r;
    logic [ID_W-1:0]    int_id_r;
    logic               spurious_r;

    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic               isr_valid;
    logic [ID_W-1:0]    isr_top;

    irq_prio_enc #(.N(NUM_IRQ)) u_win (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    // The same encoder on the in-service set finds the level iret releases.
    irq_prio_enc #(.N(NUM_IRQ)) u_isr (
        .req   (isr),
        .valid (isr_valid),
        .id    (isr_top)
    );

    // Acceptance only counts in REQ; an ack while IDLE is ignored.
    always_comb begin
        edges    = irq_in & ~irq_q;
        higher   = NUM_IRQ'(higher_mask(MAX_IRQ'(isr)));
        eligible = pending & mask & higher & {NUM_IRQ{core.int_en}};
        ack_fire = (state == REQ) && core.int_ack;
        ack_clr  = '0;
        iret_clr = '0;
        if (ack_fire) begin
            ack_clr[int_id_r] = 1'b1;
        end
        if (core.iret && isr_valid) begin
            iret_clr[isr_top] = 1'b1;
        end
    end

    // A new edge is OR-ed in last so it survives a same-cycle clear or ack.
    // For isr the iret clear is applied before the ack set, so an iret and
    // ack in one cycle leave the acked level in service.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q      <= '0;
            pending    <= '0;
            mask       <= '0;
            isr        <= '0;
            spurious_r <= 1'b0;
        end else begin
            irq_q      <= irq_in;
            pending    <= (pending & ~(pend_clr | ack_clr)) | edges;
            isr        <= (isr & ~iret_clr) | ack_clr;
            spurious_r <= core.iret && !isr_valid;
            if (mask_wr) begin
                mask <= mask_data;
            end
        end
    end

    // Once in REQ the id is frozen; a higher-priority arrival waits for the
    // next IDLE evaluation. A request is withdrawn when its pending bit is
    // cleared, its mask bit drops or the global enable drops before the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            int_req_r <= 1'b0;
            int_id_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        int_id_r  <= win_id;
                        int_req_r <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (core.int_ack) begin
                        int_req_r <= 1'b0;
                        state     <= IDLE;
                    end else if (pend_clr[int_id_r] || !mask[int_id_r] || !core.int_en) begin
                        int_req_r <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    int_req_r <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign core.int_req       = int_req_r;
    assign core.int_id        = int_id_r;
    assign core.spurious_iret = spurious_r;
    assign core.vec_addr      = VEC_BASE + DATA_W'(int_id_r) * DATA_W'(VEC_STRIDE);

    assign pending_o = pending;
    assign isr_o     = isr;

endmodule
